instr_encoder: RTL and testbench

- Inverse of the ID-stage main control decode: turns structured instruction requests (format kind, opcode, register indices, funct fields, immediate) into 32-bit RV32 instruction words.
- Feeds the debug/self-test injection port of the fetch path.
- Expands the LI pseudo-instruction into LUI+ADDI through a small FSM.
- Buffers encoded words in an output FIFO with valid/ready handshakes on both sides.

---
 rtl/instr_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: builds RV32 instruction words from structured requests.
// It is the inverse of the ID-stage main control decode and drives the debug/self-test
// injection port of the fetch path.
//
// The LI pseudo-instruction expands to LUI+ADDI through a two-state FSM. Encoded words
// wait in a small output FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   flush              synchronous clear of FIFO and FSM (word_count is kept)
//   in_valid/in_ready  request handshake
//   in_kind            0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm   request fields
//   out_valid/out_ready, out_instr, out_last   FIFO head and consumer handshake
//   err                one-cycle pulse after an illegal request is accepted
//   word_count         words popped since reset (wraps)
module instr_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_kind,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned ptrW = $clog2(DEPTH);
  localparam logic [ptrW:0] fullCount = (ptrW + 1)'(DEPTH);

  localparam logic [2:0] kindR  = 3'd0;
  localparam logic [2:0] kindI  = 3'd1;
  localparam logic [2:0] kindS  = 3'd2;
  localparam logic [2:0] kindB  = 3'd3;
  localparam logic [2:0] kindU  = 3'd4;
  localparam logic [2:0] kindJ  = 3'd5;
  localparam logic [2:0] kindLi = 3'd6;

  localparam logic [6:0] opLui  = 7'b0110111;
  localparam logic [6:0] opAddi = 7'b0010011;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] EMIT2 = 1'b1;

  logic [0:0]       state;
  logic [ptrW-1:0]  wrPtr;
  logic [ptrW-1:0]  rdPtr;
  logic [ptrW:0]    count;
  logic [31:0]      memInstr [DEPTH];
  logic             memLast  [DEPTH];
  logic [4:0]       pendRd;
  logic [11:0]      pendLo;
  logic             errQ;
  logic [CNT_W-1:0] wordCnt;

  logic [31:0] encWord;
  logic        encLast;
  logic        encPush;
  logic        encIllegal;
  logic        encTwo;
  logic [19:0] liUpper;
  logic [11:0] liLo;

  logic        notFull;
  logic        accept;
  logic        emitPush;
  logic        push;
  logic        pop;
  logic [31:0] pushWord;
  logic        pushLast;

  // Request encoder: purely a function of the current request fields.
  always_comb begin
    encWord    = 32'd0;
    encLast    = 1'b1;
    encPush    = 1'b0;
    encIllegal = 1'b0;
    encTwo     = 1'b0;
    // Bump the upper part when lo is negative so that ADDI sign extension cancels out.
    liUpper    = in_imm[31:12] + {19'd0, in_imm[11]};
    liLo       = in_imm[11:0];
    case (in_kind)
      kindR: begin
        encWord = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        encPush = 1'b1;
      end
      kindI: begin
        encWord = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        encPush = 1'b1;
      end
      kindS: begin
        encWord = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        encPush = 1'b1;
      end
      kindB: begin
        encWord = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                   in_imm[11], in_opcode};
        encPush    = ~in_imm[0];
        encIllegal = in_imm[0];
      end
      kindU: begin
        encWord = {in_imm[31:12], in_rd, in_opcode};
        encPush = 1'b1;
      end
      kindJ: begin
        encWord = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        encPush    = ~in_imm[0];
        encIllegal = in_imm[0];
      end
      kindLi: begin
        encPush = 1'b1;
        if (liUpper == 20'd0) begin
          encWord = {liLo, 5'd0, 3'b000, in_rd, opAddi};
        end else if (liLo == 12'd0) begin
          encWord = {liUpper, in_rd, opLui};
        end else begin
          encWord = {liUpper, in_rd, opLui};
          encLast = 1'b0;
          encTwo  = 1'b1;
        end
      end
      default: begin
        encIllegal = 1'b1;
      end
    endcase
  end

  // Handshake and FIFO control. in_ready looks only at registered state, never at out_ready.
  always_comb begin
    notFull   = (count < fullCount);
    in_ready  = (state == IDLE) && notFull;
    out_valid = (count != '0);
    accept    = in_valid && in_ready;
    emitPush  = (state == EMIT2) && notFull;
    push      = (accept && encPush) || emitPush;
    pop       = out_valid && out_ready;
    pushWord  = encWord;
    pushLast  = encLast;
    if (emitPush) begin
      pushWord = {pendLo, pendRd, 3'b000, pendRd, opAddi};
      pushLast = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state  <= IDLE;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      pendRd <= '0;
      pendLo <= '0;
      errQ   <= 1'b0;
      if (reset) begin
        wordCnt <= '0;
      end
    end else begin
      errQ <= accept && encIllegal;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr   <= rdPtr + 1'b1;
        wordCnt <= wordCnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && encTwo) begin
        state  <= EMIT2;
        pendRd <= in_rd;
        pendLo <= liLo;
      end else if (emitPush) begin
        state <= IDLE;
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) begin
      memInstr[wrPtr] <= pushWord;
      memLast[wrPtr]  <= pushLast;
    end
  end

  always_comb begin
    out_instr  = out_valid ? memInstr[rdPtr] : 32'd0;
    out_last   = out_valid ? memLast[rdPtr] : 1'b0;
    err        = errQ;
    word_count = wordCnt;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_kind;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_last;
  logic             err;
  logic [CNT_W-1:0] word_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .err        (err),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } ent_t;

  ent_t        q[$];
  ent_t        pend;
  bit          pendValid;
  int unsigned mCnt;
  bit          mErr;
  int          nChecks;
  int          nFails;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from shifts and masks of the field values.
  function automatic void encode(output int n, output ent_t e0, output ent_t e1,
                                 output bit ill);
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7, upper, lo;
    imm = in_imm; op = 32'(in_opcode); rd = 32'(in_rd); rs1 = 32'(in_rs1);
    rs2 = 32'(in_rs2); f3 = 32'(in_funct3); f7 = 32'(in_funct7);
    n = 1; ill = 0; e0.last = 1; e1.w = 0; e1.last = 1; e0.w = 0;
    case (in_kind)
      3'd0: e0.w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: e0.w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd2: e0.w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
      3'd3: begin
        ill = imm[0];
        e0.w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
               | (((imm >> 11) & 1) << 7) | op;
      end
      3'd4: e0.w = (imm & 32'hFFFFF000) | (rd << 7) | op;
      3'd5: begin
        ill = imm[0];
        e0.w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      3'd6: begin
        upper = ((imm >> 12) + ((imm >> 11) & 1)) & 32'hFFFFF;
        lo    = imm & 32'hFFF;
        if (upper == 0) begin
          e0.w = (lo << 20) | (rd << 7) | 32'h13;
        end else begin
          e0.w = (upper << 12) | (rd << 7) | 32'h37;
          if (lo != 0) begin
            n = 2; e0.last = 0;
            e1.w = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
          end
        end
      end
      default: ill = 1;
    endcase
    if (ill) n = 0;
  endfunction

  task automatic checkAll();
    bit expReady;
    expReady = !pendValid && (q.size() < DEPTH);
    checkVal("in_ready", 32'(in_ready), 32'(expReady));
    checkVal("out_valid", 32'(out_valid), 32'(q.size() > 0));
    checkVal("out_instr", out_instr, (q.size() > 0) ? q[0].w : 32'd0);
    checkVal("out_last", 32'(out_last), (q.size() > 0) ? 32'(q[0].last) : 32'd0);
    checkVal("err", 32'(err), 32'(mErr));
    checkVal("word_count", 32'(word_count), 32'(mCnt));
  endtask

  // Advance one clock: update the model with the applied inputs, then compare.
  task automatic tick();
    bit   expReady, accept, pop, emit, ill;
    int   n;
    ent_t e0, e1, dummy;
    expReady = !pendValid && (q.size() < DEPTH);
    pop      = (q.size() > 0) && out_ready;
    emit     = pendValid && (q.size() < DEPTH);
    encode(n, e0, e1, ill);
    accept   = in_valid && expReady;
    if (reset) begin
      q.delete(); pendValid = 0; mCnt = 0; mErr = 0;
    end else if (flush) begin
      q.delete(); pendValid = 0; mErr = 0;
    end else begin
      if (pop) begin
        dummy = q.pop_front();
        mCnt = (mCnt + 1) % (1 << CNT_W);
      end
      if (emit) begin
        q.push_back(pend); pendValid = 0;
      end
      mErr = accept && ill;
      if (accept && !ill) begin
        q.push_back(e0);
        if (n == 2) begin
          pend = e1; pendValid = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic setReq(input logic [2:0] k, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    in_kind = k; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < DEPTH + 3; i++) tick();
  endtask

  int unsigned savedCnt;
  int          mode;

  initial begin
    nChecks = 0; nFails = 0; pendValid = 0; mCnt = 0; mErr = 0;
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    setReq(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    checkVal("rst_in_ready", 32'(in_ready), 1);
    checkVal("rst_word_count", 32'(word_count), 0);
    tick();

    // R-type
    setReq(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    in_valid = 1; tick(); in_valid = 0;
    checkVal("r_word", out_instr, 32'h403100B3);
    checkVal("r_last", 32'(out_last), 1);
    drain();

    // B-type legal, then misaligned
    setReq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    out_ready = 0; in_valid = 1; tick(); in_valid = 0;
    checkVal("b_word", out_instr, 32'hFE208EE3);
    drain();
    in_imm = 32'd3; in_valid = 1; tick(); in_valid = 0;
    checkVal("b_odd_err", 32'(err), 1);
    checkVal("b_odd_ready", 32'(in_ready), 1);
    tick();
    checkVal("b_odd_err_clr", 32'(err), 0);

    // LI two words
    out_ready = 0;
    setReq(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    in_valid = 1; tick(); in_valid = 0;
    checkVal("li_lui", out_instr, 32'h123462B7);
    checkVal("li_lui_last", 32'(out_last), 0);
    checkVal("li_emit2_ready", 32'(in_ready), 0);
    tick();
    out_ready = 1; tick();
    checkVal("li_addi", out_instr, 32'hFFF28293);
    drain();

    // LI single ADDI, single LUI
    out_ready = 0; in_imm = 32'h000007FF; in_valid = 1; tick(); in_valid = 0;
    checkVal("li_small", out_instr, 32'h7FF00293);
    drain();
    out_ready = 0; in_imm = 32'h12345000; in_valid = 1; tick(); in_valid = 0;
    checkVal("li_lui_only", out_instr, 32'h123452B7);
    checkVal("li_lui_only_last", 32'(out_last), 1);
    drain();

    // Fill the FIFO, then retry with out_ready raised in the same cycle
    savedCnt = mCnt;
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      setReq(3'd0, 7'h33, 5'(i + 10), 5'd2, 5'd3, 3'd0, 7'h00, 32'd0);
      tick();
    end
    checkVal("full_ready", 32'(in_ready), 0);
    in_rd = 5'd20; out_ready = 1;
    tick();
    tick();
    drain();
    checkVal("full_drain_cnt", 32'(word_count), 32'((savedCnt + DEPTH + 1) % (1 << CNT_W)));

    // Flush during EMIT2, then reset during EMIT2
    for (int r = 0; r < 2; r++) begin
      savedCnt = mCnt; out_ready = 0;
      setReq(3'd1, 7'h13, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'h123);
      in_valid = 1; tick();
      setReq(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
      tick(); in_valid = 0; tick();
      if (r == 0) flush = 1; else reset = 1;
      tick();
      flush = 0; reset = 0;
      checkVal("abort_valid", 32'(out_valid), 0);
      checkVal("abort_ready", 32'(in_ready), 1);
      checkVal("abort_cnt", 32'(word_count), (r == 0) ? savedCnt : 32'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      setReq(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 3'($urandom), 7'($urandom), $urandom);
      mode = $urandom_range(0, 4);
      if (mode == 0) in_imm = in_imm & 32'hFFFFF000;
      else if (mode == 1) in_imm = in_imm & 32'h7FF;
      else if (mode == 2) in_imm = 32'hFFFFF800 | (in_imm & 32'h7FF);
      else if (mode == 3) in_imm = in_imm & 32'hFFFFFFFE;
      tick();
    end
    flush = 0; reset = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
